pipeline_controller: RTL and testbench

Sequencing and hazard controller for the 5-stage pipeline front end. It decides every cycle whether the pipeline advances, and drives the PC write enable, the IF/ID write and flush controls, and the ID/EX bubble. It resolves load-use stalls and taken branches/jumps, and runs the pipeline in continuous or single-step (debug) mode. On a decoded HALT it freezes fetch, drains the in-flight instructions, and parks in a halted state.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/load_use_detector.sv | 16 +
 rtl/pipeline_controller.sv | 136 +++++++++++++
 tb/tb_pipeline_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline sequencing controller: FSM state
// encoding and default geometry.
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int DEF_NB_REG       = 5;
    localparam int DEF_NB_CNT       = 32;
    localparam int DEF_DRAIN_CYCLES = 3;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check between the EX load and the ID
// instruction's source registers; register 0 never creates a hazard.
module load_use_detector #(
    parameter int NB_REG = 5
) (
    input  logic              i_EX_mem_read,
    input  logic [NB_REG-1:0] i_EX_rt,
    input  logic [NB_REG-1:0] i_ID_rs,
    input  logic [NB_REG-1:0] i_ID_rt,
    output logic              stall
);

    assign stall = i_EX_mem_read && (i_EX_rt != '0)
                && ((i_EX_rt == i_ID_rs) || (i_EX_rt == i_ID_rt));

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencing/hazard controller: advance enable, PC/IF-ID write,
// flush and bubble control, single-step mode and HALT drain.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_REG       = DEF_NB_REG,
    parameter int NB_CNT       = DEF_NB_CNT,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_debug_mode,
    input  logic              i_step,
    input  logic              i_halt_decoded,
    input  logic [NB_REG-1:0] i_ID_rs,
    input  logic [NB_REG-1:0] i_ID_rt,
    input  logic              i_EX_mem_read,
    input  logic [NB_REG-1:0] i_EX_rt,
    input  logic              i_branch_taken,
    input  logic              i_jump,
    output logic              o_pipe_enable,
    output logic              o_PC_write,
    output logic              o_IF_ID_write,
    output logic              o_IF_flush,
    output logic              o_ID_EX_bubble,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_count
);

    // Counter holds DRAIN_CYCLES-1 at most; keep it at least one bit wide.
    localparam int NB_DRAIN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]          state_reg, state_next;
    logic                mode_reg, mode_next;
    logic                step_q_reg;
    logic [NB_DRAIN-1:0] drain_cnt_reg, drain_cnt_next;
    logic [NB_CNT-1:0]   cycle_cnt_reg;

    logic stall;
    logic active;
    logic en;
    logic pc_write, if_id_write, if_flush, id_ex_bubble;

    load_use_detector #(
        .NB_REG (NB_REG)
    ) u_load_use_detector (
        .i_EX_mem_read (i_EX_mem_read),
        .i_EX_rt       (i_EX_rt),
        .i_ID_rs       (i_ID_rs),
        .i_ID_rt       (i_ID_rt),
        .stall         (stall)
    );

    // In single-step mode only the rising edge of i_step grants a cycle.
    assign active = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign en     = active && (mode_reg ? (i_step && !step_q_reg) : 1'b1);

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        drain_cnt_next = drain_cnt_reg;
        pc_write       = 1'b0;
        if_id_write    = 1'b0;
        if_flush       = 1'b0;
        id_ex_bubble   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    mode_next  = i_debug_mode;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (stall) begin
                        id_ex_bubble = 1'b1;
                    end else if (i_halt_decoded) begin
                        if_flush       = 1'b1;
                        drain_cnt_next = NB_DRAIN'(DRAIN_CYCLES - 1);
                        state_next     = ST_DRAIN;
                    end else if (i_branch_taken || i_jump) begin
                        pc_write = 1'b1;
                        if_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    if_flush = 1'b1;
                    if (drain_cnt_reg != '0) begin
                        drain_cnt_next = drain_cnt_reg - 1'b1;
                    end else begin
                        state_next = ST_HALTED;
                    end
                end
            end
            default: begin
                // HALTED is sticky until reset.
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= 1'b0;
            step_q_reg    <= 1'b0;
            drain_cnt_reg <= '0;
            cycle_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            step_q_reg    <= i_step;
            drain_cnt_reg <= drain_cnt_next;
            if (en) begin
                cycle_cnt_reg <= cycle_cnt_reg + NB_CNT'(1);
            end
        end
    end

    assign o_pipe_enable  = en;
    assign o_PC_write     = pc_write;
    assign o_IF_ID_write  = if_id_write;
    assign o_IF_flush     = if_flush;
    assign o_ID_EX_bubble = id_ex_bubble;
    assign o_state        = state_reg;
    assign o_halted       = (state_reg == ST_HALTED);
    assign o_cycle_count  = cycle_cnt_reg;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed and randomized bench for pipeline_controller, compared each cycle
// against a behavioural model of the sequencing rules.
module tb_pipeline_controller;

    localparam int NB_REG       = 5;
    localparam int NB_CNT       = 32;
    localparam int DRAIN_CYCLES = 3;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic              i_reset_n;
    logic              i_start, i_debug_mode, i_step, i_halt_decoded;
    logic [NB_REG-1:0] i_ID_rs, i_ID_rt, i_EX_rt;
    logic              i_EX_mem_read, i_branch_taken, i_jump;
    logic              o_pipe_enable, o_PC_write, o_IF_ID_write, o_IF_flush, o_ID_EX_bubble;
    logic [1:0]        o_state;
    logic              o_halted;
    logic [NB_CNT-1:0] o_cycle_count;

    pipeline_controller #(
        .NB_REG       (NB_REG),
        .NB_CNT       (NB_CNT),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_start        (i_start),
        .i_debug_mode   (i_debug_mode),
        .i_step         (i_step),
        .i_halt_decoded (i_halt_decoded),
        .i_ID_rs        (i_ID_rs),
        .i_ID_rt        (i_ID_rt),
        .i_EX_mem_read  (i_EX_mem_read),
        .i_EX_rt        (i_EX_rt),
        .i_branch_taken (i_branch_taken),
        .i_jump         (i_jump),
        .o_pipe_enable  (o_pipe_enable),
        .o_PC_write     (o_PC_write),
        .o_IF_ID_write  (o_IF_ID_write),
        .o_IF_flush     (o_IF_flush),
        .o_ID_EX_bubble (o_ID_EX_bubble),
        .o_state        (o_state),
        .o_halted       (o_halted),
        .o_cycle_count  (o_cycle_count)
    );

    typedef struct {
        logic              start, dbg, step, halt;
        logic [NB_REG-1:0] rs, rt, exrt;
        logic              memrd, br, jmp;
    } stim_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 idle, 1 running, 2 draining, 3 halted.
    int          m_phase;
    bit          m_mode;
    bit          m_prev_step;
    int          m_drain_left;
    logic [31:0] m_count;

    function automatic stim_t idle_stim();
        stim_t s;
        s.start = 0; s.dbg = 0; s.step = 0; s.halt = 0;
        s.rs = '0; s.rt = '0; s.exrt = '0;
        s.memrd = 0; s.br = 0; s.jmp = 0;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_mode       = 0;
        m_prev_step  = 0;
        m_drain_left = 0;
        m_count      = '0;
    endtask

    task automatic drive(input stim_t s);
        i_start        = s.start;
        i_debug_mode   = s.dbg;
        i_step         = s.step;
        i_halt_decoded = s.halt;
        i_ID_rs        = s.rs;
        i_ID_rt        = s.rt;
        i_EX_rt        = s.exrt;
        i_EX_mem_read  = s.memrd;
        i_branch_taken = s.br;
        i_jump         = s.jmp;
    endtask

    task automatic check_all(input string tag, input bit en, input bit pc, input bit ifid,
                             input bit fl, input bit bub);
        check($sformatf("%s.pipe_enable", tag), 32'(o_pipe_enable), 32'(en));
        check($sformatf("%s.PC_write", tag), 32'(o_PC_write), 32'(pc));
        check($sformatf("%s.IF_ID_write", tag), 32'(o_IF_ID_write), 32'(ifid));
        check($sformatf("%s.IF_flush", tag), 32'(o_IF_flush), 32'(fl));
        check($sformatf("%s.ID_EX_bubble", tag), 32'(o_ID_EX_bubble), 32'(bub));
        check($sformatf("%s.state", tag), 32'(o_state), 32'(m_phase));
        check($sformatf("%s.halted", tag), 32'(o_halted), 32'(m_phase == 3));
        check($sformatf("%s.cycle_count", tag), o_cycle_count, m_count);
    endtask

    task automatic do_cycle(input stim_t s, input string tag);
        bit hazard, en, pc, ifid, fl, bub;
        @(posedge i_clk);
        #1;
        drive(s);
        @(negedge i_clk);
        hazard = s.memrd && (s.exrt != 0) && ((s.exrt == s.rs) || (s.exrt == s.rt));
        en = (m_phase == 1 || m_phase == 2) && (m_mode ? (s.step && !m_prev_step) : 1'b1);
        pc = 0; ifid = 0; fl = 0; bub = 0;
        if (en && m_phase == 1) begin
            if (hazard)            bub = 1;
            else if (s.halt)       fl = 1;
            else if (s.br || s.jmp) begin pc = 1; fl = 1; end
            else begin pc = 1; ifid = 1; end
        end else if (en && m_phase == 2) begin
            fl = 1;
        end
        check_all(tag, en, pc, ifid, fl, bub);
        $display("[TB] %s: en=%0b pc=%0b ifid=%0b flush=%0b bubble=%0b state=%0d count=%0d",
                 tag, o_pipe_enable, o_PC_write, o_IF_ID_write, o_IF_flush, o_ID_EX_bubble,
                 o_state, o_cycle_count);
        // State as it stands after the coming rising edge.
        case (m_phase)
            0: if (s.start) begin m_mode = s.dbg; m_phase = 1; end
            1: if (en && !hazard && s.halt) begin m_phase = 2; m_drain_left = DRAIN_CYCLES; end
            2: if (en) begin
                   m_drain_left--;
                   if (m_drain_left == 0) m_phase = 3;
               end
            default: ;
        endcase
        if (en) m_count = m_count + 32'd1;
        m_prev_step = s.step;
    endtask

    task automatic reset_mid(input string tag);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag, 0, 0, 0, 0, 0);
        $display("[TB] %s: reset asserted state=%0d count=%0d", tag, o_state, o_cycle_count);
        drive(idle_stim());
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    initial begin
        stim_t s;
        i_reset_n = 1'b0;
        drive(idle_stim());
        model_reset();
        #2;
        check_all("por", 0, 0, 0, 0, 0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Continuous run: advance, load-use, branch/jump priorities.
        s = idle_stim();
        do_cycle(s, "idle");
        s.start = 1;
        do_cycle(s, "start_cont");
        s = idle_stim();
        do_cycle(s, "advance");
        s.memrd = 1; s.exrt = 5; s.rs = 5;
        do_cycle(s, "lu_stall");
        s.exrt = 0;
        do_cycle(s, "lu_rt0");
        s = idle_stim(); s.br = 1;
        do_cycle(s, "branch");
        s.memrd = 1; s.exrt = 7; s.rt = 7;
        do_cycle(s, "branch_stall");
        s = idle_stim(); s.jmp = 1;
        do_cycle(s, "jump");
        s = idle_stim();
        do_cycle(s, "pre_reset");
        reset_mid("reset_mid_run");

        // Single-step: a long hold and two pulses grant exactly three cycles.
        s = idle_stim(); s.start = 1; s.dbg = 1;
        do_cycle(s, "start_dbg");
        s = idle_stim(); s.step = 1;
        repeat (5) do_cycle(s, "step_hold");
        s.step = 0; do_cycle(s, "step_low");
        s.step = 1; do_cycle(s, "step_pulse1");
        s.step = 0; do_cycle(s, "step_low");
        s.step = 1; do_cycle(s, "step_pulse2");
        s.step = 0; do_cycle(s, "step_low");
        check("step_count", o_cycle_count, 32'd3);

        // HALT drain and sticky HALTED.
        reset_mid("reset_before_halt");
        s = idle_stim(); s.start = 1;
        do_cycle(s, "start_cont");
        s = idle_stim(); s.halt = 1;
        repeat (DRAIN_CYCLES + 1) do_cycle(s, "halt_drain");
        s = idle_stim();
        do_cycle(s, "halted");
        check("halted_state", 32'(o_state), 32'd3);
        s.start = 1;
        do_cycle(s, "start_ignored");
        do_cycle(idle_stim(), "still_halted");
        check("sticky_state", 32'(o_state), 32'd3);

        // HALT arriving under a load-use stall waits for the stall to clear.
        reset_mid("reset_before_halt_stall");
        s = idle_stim(); s.start = 1;
        do_cycle(s, "start_cont");
        s = idle_stim(); s.halt = 1; s.memrd = 1; s.exrt = 3; s.rs = 3;
        do_cycle(s, "halt_stall");
        s.memrd = 0;
        do_cycle(s, "halt_accept");
        do_cycle(idle_stim(), "drain_first");
        check("halt_stall_drain_state", 32'(o_state), 32'd2);

        // Randomized episodes, each from a fresh reset.
        for (int ep = 0; ep < 6; ep++) begin
            reset_mid($sformatf("rand_reset%0d", ep));
            for (int c = 0; c < 300; c++) begin
                s.start = ($urandom % 8) == 0;
                s.dbg   = $urandom % 2;
                s.step  = $urandom % 2;
                s.halt  = ($urandom % 25) == 0;
                s.rs    = NB_REG'($urandom_range(0, 3));
                s.rt    = NB_REG'($urandom_range(0, 3));
                s.exrt  = NB_REG'($urandom_range(0, 3));
                s.memrd = $urandom % 2;
                s.br    = ($urandom % 4) == 0;
                s.jmp   = ($urandom % 6) == 0;
                do_cycle(s, $sformatf("rand%0d_%0d", ep, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
